// File: rtl/bin2bcd_if.sv
// Request/result bundle between a bin2bcd_seq converter and its client.
// The client (master) drives the request; the converter (slave) returns digits.
interface bin2bcd_if;
  logic       start;
  logic [7:0] bin;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic [3:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       neg;

  modport master (
    output start, bin, signed_mode,
    input  busy, done, hund, tens, ones, neg
  );

  modport slave (
    input  start, bin, signed_mode,
    output busy, done, hund, tens, ones, neg
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit (optionally signed) value to three
// BCD digits plus sign, with optional leading-zero blanking for 7-seg decoders.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold last result
// SHIFT  | eight add-3/shift steps on {scratch, binreg}
// FINISH | register digits (with blanking) and pulse done
module bin2bcd_seq #(
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [3:0] BLANK_CODE = 4'b1111
) (
  input  logic      clk,
  input  logic      rst_n,
  bin2bcd_if.slave  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]  state;
  logic [7:0]  binreg;
  logic [11:0] scratch;
  logic [11:0] adj;
  logic [2:0]  cnt;
  logic        sign;
  logic        neg_in;
  logic [7:0]  mag;
  logic [3:0]  d_h;
  logic [3:0]  d_t;

  // A negative input only arises with bin[7]=1, so magnitude 0 never carries sign
  assign neg_in = bus.signed_mode & bus.bin[7];
  assign mag    = neg_in ? (~bus.bin + 8'd1) : bus.bin;

  assign d_h = scratch[11:8];
  assign d_t = scratch[7:4];

  always_comb begin
    adj = scratch;
    if (scratch[3:0]  >= 4'd5) adj[3:0]  = scratch[3:0]  + 4'd3;
    if (scratch[7:4]  >= 4'd5) adj[7:4]  = scratch[7:4]  + 4'd3;
    if (scratch[11:8] >= 4'd5) adj[11:8] = scratch[11:8] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      binreg   <= 8'd0;
      scratch  <= 12'd0;
      cnt      <= 3'd0;
      sign     <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hund <= 4'd0;
      bus.tens <= 4'd0;
      bus.ones <= 4'd0;
      bus.neg  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            binreg   <= mag;
            scratch  <= 12'd0;
            sign     <= neg_in;
            cnt      <= 3'd0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[10:0], binreg[7]};
          binreg  <= {binreg[6:0], 1'b0};
          cnt     <= cnt + 3'd1;
          if (cnt == 3'd7) state <= FINISH;
        end
        FINISH: begin
          bus.hund <= (BLANK_LZ && d_h == 4'd0) ? BLANK_CODE : d_h;
          bus.tens <= (BLANK_LZ && d_h == 4'd0 && d_t == 4'd0) ? BLANK_CODE : d_t;
          bus.ones <= scratch[3:0];
          bus.neg  <= sign;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench: one converter with leading-zero blanking, one without,
// both fed the same request stream and checked against hand-computed digits.
module tb_bin2bcd_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bin2bcd_if bus_a ();
  bin2bcd_if bus_b ();

  assign bus_b.start       = bus_a.start;
  assign bus_b.bin         = bus_a.bin;
  assign bus_b.signed_mode = bus_a.signed_mode;

  bin2bcd_seq #(.BLANK_LZ(1'b1), .BLANK_CODE(4'b1111)) u_blank (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  bin2bcd_seq #(.BLANK_LZ(1'b0), .BLANK_CODE(4'b1111)) u_plain (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic n, input logic [3:0] h, input logic [3:0] t,
                                     input logic [3:0] o);
    return {3'b000, n, h, t, o};
  endfunction

  function automatic logic [15:0] res_a();
    return {3'b000, bus_a.neg, bus_a.hund, bus_a.tens, bus_a.ones};
  endfunction

  function automatic logic [15:0] res_b();
    return {3'b000, bus_b.neg, bus_b.hund, bus_b.tens, bus_b.ones};
  endfunction

  // Wait (bounded) for done after the current edge; returns edges elapsed, 99 on timeout
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus_a.done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic convert(input string tag, input logic [7:0] b, input logic sm,
                         input logic [15:0] exp_a, input logic [15:0] exp_b);
    int n;
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.bin = b;
    bus_a.signed_mode = sm;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    chk({tag, " busy"}, {15'd0, bus_a.busy}, 16'd1);
    wait_done(n);
    chk({tag, " latency"}, 16'(n), 16'd9);
    chk({tag, " blank"}, res_a(), exp_a);
    chk({tag, " plain"}, res_b(), exp_b);
    chk({tag, " busy_end"}, {15'd0, bus_a.busy}, 16'd0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {15'd0, bus_a.done}, 16'd0);
  endtask

  initial begin
    int n;
    int dones;
    vectors = 0;
    miscompares = 0;
    bus_a.start = 1'b0;
    bus_a.bin = 8'd0;
    bus_a.signed_mode = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset outs", res_a(), pk(0, 0, 0, 0));
    chk("reset busy_done", {14'd0, bus_a.busy, bus_a.done}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    convert("u255", 8'hFF, 1'b0, pk(0, 2, 5, 5), pk(0, 2, 5, 5));
    convert("zero", 8'h00, 1'b0, pk(0, 4'hF, 4'hF, 0), pk(0, 0, 0, 0));
    convert("s-128", 8'h80, 1'b1, pk(1, 1, 2, 8), pk(1, 1, 2, 8));
    convert("s-1", 8'hFF, 1'b1, pk(1, 4'hF, 4'hF, 1), pk(1, 0, 0, 1));
    convert("s127", 8'h7F, 1'b1, pk(0, 1, 2, 7), pk(0, 1, 2, 7));
    convert("u7", 8'd7, 1'b0, pk(0, 4'hF, 4'hF, 7), pk(0, 0, 0, 7));
    convert("u40", 8'd40, 1'b0, pk(0, 4'hF, 4, 0), pk(0, 0, 4, 0));
    convert("u100", 8'd100, 1'b0, pk(0, 1, 0, 0), pk(0, 1, 0, 0));
    convert("s100", 8'd100, 1'b1, pk(0, 1, 0, 0), pk(0, 1, 0, 0));

    // Start held high: back-to-back conversions; bin change while busy is ignored
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.bin = 8'd42;
    bus_a.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus_a.bin = 8'd99;
    wait_done(n);
    chk("b2b first latency", 16'(n), 16'd9);
    chk("b2b first blank", res_a(), pk(0, 4'hF, 4, 2));
    chk("b2b first plain", res_b(), pk(0, 0, 4, 2));
    wait_done(n);
    bus_a.start = 1'b0;
    chk("b2b second latency", 16'(n), 16'd10);
    chk("b2b second blank", res_a(), pk(0, 4'hF, 9, 9));
    repeat (3) @(posedge clk);
    #1;
    chk("b2b idle", {14'd0, bus_a.busy, bus_a.done}, 16'd0);

    // Reset mid-conversion
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.bin = 8'd200;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort busy_done", {14'd0, bus_a.busy, bus_a.done}, 16'd0);
    chk("abort outs", res_a(), pk(0, 0, 0, 0));
    chk("abort plain", res_b(), pk(0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus_a.done || bus_b.done) dones++;
    end
    chk("abort no_done", 16'(dones), 16'd0);
    chk("abort hold", res_a(), pk(0, 0, 0, 0));
    convert("u13", 8'd13, 1'b0, pk(0, 4'hF, 1, 3), pk(0, 0, 1, 3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential shift-add-3 (double-dabble) converter. Turns the calculator's 8-bit result into three BCD digits plus a sign flag. Sits directly upstream of the per-digit BCD-to-seven-segment decoders. Blanked digits are driven with a non-decimal code, so the decoder's default case renders them dark.

Parameters:
BLANK_LZ, 1, 1 = leading-zero blanking enabled; 0 = always show three digits
BLANK_CODE, 4'b1111, code driven on blanked digits; must be outside 0-9

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled on rising clk edge while idle
bin  input  8  value to convert, sampled with start
signed_mode  input  1  1 = treat bin as two's complement; sampled with start
busy  output  1  conversion in progress
done  output  1  one-cycle pulse when new digits are valid
hund  output  4  hundreds digit (BCD or BLANK_CODE)
tens  output  4  tens digit (BCD or BLANK_CODE)
ones  output  4  ones digit (BCD, never blanked)
neg  output  1  result is negative (signed_mode only)

Behaviour:
Reset and clocking:
- One clock domain. rst_n low asynchronously clears all state: FSM=IDLE, busy=0, done=0, hund=tens=ones=4'b0000, neg=0, shift counter=0.
- All outputs registered.

FSM states IDLE, SHIFT, FINISH:
- IDLE: on edge with start=1, capture the magnitude into the binary shift register, clear the 12-bit BCD scratch, latch the sign, set busy=1, counter=0, go to SHIFT.
- Magnitude rule: if signed_mode=1 and bin[7]=1, magnitude = (~bin + 1) as 8-bit unsigned, and sign=1. For bin=8'h80 this gives 128. Otherwise magnitude = bin and sign=0.
- SHIFT: each cycle, first add 3 to every scratch nibble that is >=5. Then shift {scratch, binreg} left by 1 and increment the counter. After the 8th shift (counter reaches 7 on that edge), go to FINISH.
- FINISH: register the digits into hund/tens/ones with blanking applied, and set neg=sign. Pulse done=1 for exactly one cycle, set busy=0, go to IDLE.

Timing:
- Start accepted at edge k. Shifts occur at edges k+1..k+8. Outputs update and done rises at edge k+9.
- busy is high from after edge k until edge k+9.
- A start asserted during the done-high cycle is accepted at edge k+10, giving back-to-back conversions.
- start while busy=1 is ignored; bin and signed_mode changes while busy are ignored.

Output holding:
- hund/tens/ones/neg hold the last completed result until the next FINISH.
- Outputs never show intermediate scratch values.

Blanking (BLANK_LZ=1):
- hund = BLANK_CODE if the hundreds digit is 0.
- tens = BLANK_CODE if both hundreds and tens digits are 0.
- ones is always numeric.
- With BLANK_LZ=0, all digits are numeric.

Other rules:
- neg=1 with magnitude 0 is impossible (two's complement of 0 gives 0, sign forced 0).
- Reset mid-conversion aborts immediately: no done pulse, outputs at reset values.

Test Plan:
- Unsigned 255: bin=8'hFF, signed_mode=0, start pulse at edge k -> busy high, done high after edge k+9 only; hund=2, tens=5, ones=5, neg=0.
- Zero with blanking: bin=0, signed_mode=0 -> hund=4'hF, tens=4'hF, ones=0, neg=0. Repeat with BLANK_LZ=0 -> 0,0,0.
- Signed extremes: bin=8'h80, signed_mode=1 -> neg=1, 1,2,8. bin=8'hFF, signed_mode=1 -> neg=1, F,F,1. bin=8'h7F, signed_mode=1 -> neg=0, 1,2,7.
- Tens-only blanking: bin=8'd7 -> F,F,7. bin=8'd40 -> F,4,0. bin=8'd100 -> 1,0,0.
- Handshake: start held high for 20 cycles with bin=8'd42 -> first done after edge k+9, second done after edge k+19. Changing bin to 99 while busy does not affect the first result (42 shown first).
- Reset mid-conversion: start with bin=8'd200, drop rst_n asynchronously at k+4 -> busy=0, done never pulses, outputs 0,0,0, neg=0. Next start with 8'd13 -> F,1,3 after 9 cycles.
